// File: rtl/tetris_pkg.sv
// -----------------------------------------------------------------------------
// tetris_pkg
// Shared constants and types for the Tetris board store and its line-clear
// engine.
//   BOARD_COLS / BOARD_ROWS : default playfield size (10 x 20 cells)
//   ROW_FULL                : pattern of a completely occupied row
//   LINES_MAX               : saturation value of the cumulative line counter
//   clear_state_e           : line-clear FSM states
// -----------------------------------------------------------------------------
package tetris_pkg;

  localparam int BOARD_COLS = 10;
  localparam int BOARD_ROWS = 20;

  localparam logic [BOARD_COLS-1:0] ROW_FULL = 10'h3FF;

  localparam int LINES_MAX = 255;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } clear_state_e;

endpackage : tetris_pkg

// File: rtl/tetris_clear_ctrl.sv
// -----------------------------------------------------------------------------
// tetris_clear_ctrl
// Line-clear sequencer. Scans rows bottom-up; on a full row it collapses the
// stack above it one row per cycle, then rescans the same row index.
// Ports:
//   CLOCK_50, resetn     : clock, asynchronous active-low reset
//   clear_req            : start a pass (ignored unless idle)
//   row_full             : grid row at scan_row is all ones
//   scan_row             : row currently being examined
//   shift_row            : destination row of the current shift step
//   shift_en             : copy row[shift_row-1] into row[shift_row]
//   zero_top             : clear row 0 (last step of a collapse)
//   clear_busy           : engine active (SCAN, SHIFT, DONE)
//   clear_done           : one-cycle completion pulse
//   lines_cleared        : rows removed by the last pass
//   total_lines          : cumulative rows removed, saturating
// -----------------------------------------------------------------------------
module tetris_clear_ctrl
  import tetris_pkg::*;
#(
  parameter int ROWS = BOARD_ROWS
) (
  input  logic       CLOCK_50,
  input  logic       resetn,
  input  logic       clear_req,
  input  logic       row_full,
  output logic [4:0] scan_row,
  output logic [4:0] shift_row,
  output logic       shift_en,
  output logic       zero_top,
  output logic       clear_busy,
  output logic       clear_done,
  output logic [2:0] lines_cleared,
  output logic [7:0] total_lines
);

  localparam logic [4:0] LAST_ROW = 5'(ROWS - 1);

  clear_state_e state_q, state_d;
  logic [4:0]   r_q, s_q, count_q;
  logic [8:0]   total_sum;

  // State register
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic
  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (clear_req) state_d = SCAN;
      SCAN: begin
        if (row_full)         state_d = SHIFT;
        else if (r_q == 5'd0) state_d = DONE;
      end
      SHIFT: if (s_q == 5'd0) state_d = SCAN;
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    clear_busy = (state_q != IDLE);
    clear_done = (state_q == DONE);
    shift_en   = (state_q == SHIFT) && (s_q != 5'd0);
    zero_top   = (state_q == SHIFT) && (s_q == 5'd0);
    scan_row   = r_q;
    shift_row  = s_q;
  end

  assign total_sum = {1'b0, total_lines} + {4'b0, count_q};

  // Pointers and counters
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      r_q           <= '0;
      s_q           <= '0;
      count_q       <= '0;
      lines_cleared <= '0;
      total_lines   <= '0;
    end else begin
      unique case (state_q)
        IDLE: if (clear_req) begin
          r_q     <= LAST_ROW;
          count_q <= '0;
        end
        SCAN: begin
          if (row_full)         s_q <= r_q;
          else if (r_q != 5'd0) r_q <= r_q - 5'd1;
        end
        SHIFT: begin
          // r_q is left alone so the row that dropped into it is rechecked.
          if (s_q == 5'd0) count_q <= count_q + 5'd1;
          else             s_q     <= s_q - 5'd1;
        end
        DONE: begin
          lines_cleared <= (count_q > 5'd7) ? 3'd7 : count_q[2:0];
          total_lines   <= (total_sum > 9'(LINES_MAX)) ? 8'(LINES_MAX)
                                                        : total_sum[7:0];
        end
        default: ;
      endcase
    end
  end

endmodule : tetris_clear_ctrl

// File: rtl/tetris_board_store.sv
// -----------------------------------------------------------------------------
// tetris_board_store
// Occupancy grid for the Tetris playfield (row 0 = top, column 0 = left) with a
// combinational read port, a single-cell write port and a line-clear engine.
// Ports:
//   CLOCK_50, resetn            : clock, asynchronous active-low reset
//   board_rx/ry -> board_rdata  : combinational read, out of range reads 1
//   board_we/wx/wy/wdata        : cell write, dropped while clearing or OOR
//   clear_req                   : start a line-clear pass
//   clear_busy/clear_done       : engine status / completion pulse
//   lines_cleared/total_lines   : rows removed last pass / cumulative (sat.)
// Optional (TETRIS_BOARD_VGA_PORT_EN):
//   vga_x/vga_y -> vga_rdata    : renderer read port, out of range reads 0
// -----------------------------------------------------------------------------
module tetris_board_store
  import tetris_pkg::*;
#(
  parameter int COLS = BOARD_COLS,
  parameter int ROWS = BOARD_ROWS
) (
  input  logic       CLOCK_50,
  input  logic       resetn,
  input  logic [3:0] board_rx,
  input  logic [4:0] board_ry,
  output logic       board_rdata,
  input  logic       board_we,
  input  logic [3:0] board_wx,
  input  logic [4:0] board_wy,
  input  logic       board_wdata,
  input  logic       clear_req,
  output logic       clear_busy,
  output logic       clear_done,
  output logic [2:0] lines_cleared,
`ifdef TETRIS_BOARD_VGA_PORT_EN
  input  logic [3:0] vga_x,
  input  logic [4:0] vga_y,
  output logic       vga_rdata,
`endif
  output logic [7:0] total_lines
);

  localparam logic [3:0] COLS_L = 4'(COLS);
  localparam logic [4:0] ROWS_L = 5'(ROWS);

  logic [COLS-1:0] grid [ROWS];

  logic [4:0] scan_row, shift_row;
  logic       shift_en, zero_top, row_full, write_ok;

  tetris_clear_ctrl #(.ROWS(ROWS)) u_clear_ctrl (
    .CLOCK_50      (CLOCK_50),
    .resetn        (resetn),
    .clear_req     (clear_req),
    .row_full      (row_full),
    .scan_row      (scan_row),
    .shift_row     (shift_row),
    .shift_en      (shift_en),
    .zero_top      (zero_top),
    .clear_busy    (clear_busy),
    .clear_done    (clear_done),
    .lines_cleared (lines_cleared),
    .total_lines   (total_lines)
  );

  assign row_full = (grid[scan_row] == ROW_FULL[COLS-1:0]);

  assign write_ok = board_we && !clear_busy &&
                    (board_wx < COLS_L) && (board_wy < ROWS_L);

  // NOTE: the grid is small register storage that must read as empty straight
  // out of reset (including mid-pass), so it sits in the async reset branch;
  // a RAM-style array would be left unreset.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      for (int y = 0; y < ROWS; y++) grid[y] <= '0;
    end else if (zero_top) begin
      grid[0] <= '0;
    end else if (shift_en) begin
      grid[shift_row] <= grid[shift_row - 5'd1];
    end else if (write_ok) begin
      grid[board_wy][board_wx] <= board_wdata;
    end
  end

  // Out-of-range reads as wall so collision checks need no bounds logic.
  assign board_rdata = ((board_rx < COLS_L) && (board_ry < ROWS_L))
                       ? grid[board_ry][board_rx] : 1'b1;

`ifdef TETRIS_BOARD_VGA_PORT_EN
  // Out-of-range reads as blank so the renderer draws nothing there.
  assign vga_rdata = ((vga_x < COLS_L) && (vga_y < ROWS_L))
                     ? grid[vga_y][vga_x] : 1'b0;
`endif

endmodule : tetris_board_store

// File: tb/tb_tetris_board_store.sv
// -----------------------------------------------------------------------------
// tb_tetris_board_store
// Directed self-checking bench for tetris_board_store. Inputs change and
// outputs are sampled on the falling clock edge.
// -----------------------------------------------------------------------------
`timescale 1ns/100ps
module tb_tetris_board_store;

  logic       CLOCK_50 = 1'b0;
  logic       resetn;
  logic [3:0] board_rx;
  logic [4:0] board_ry;
  logic       board_rdata;
  logic       board_we;
  logic [3:0] board_wx;
  logic [4:0] board_wy;
  logic       board_wdata;
  logic       clear_req;
  logic       clear_busy;
  logic       clear_done;
  logic [2:0] lines_cleared;
  logic [7:0] total_lines;
`ifdef TETRIS_BOARD_VGA_PORT_EN
  logic [3:0] vga_x = '0;
  logic [4:0] vga_y = '0;
  logic       vga_rdata;
`endif

  int n_assert = 0;
  int n_fail   = 0;

  always #10 CLOCK_50 = ~CLOCK_50;

  tetris_board_store dut (
    .CLOCK_50      (CLOCK_50),
    .resetn        (resetn),
    .board_rx      (board_rx),
    .board_ry      (board_ry),
    .board_rdata   (board_rdata),
    .board_we      (board_we),
    .board_wx      (board_wx),
    .board_wy      (board_wy),
    .board_wdata   (board_wdata),
    .clear_req     (clear_req),
    .clear_busy    (clear_busy),
    .clear_done    (clear_done),
    .lines_cleared (lines_cleared),
`ifdef TETRIS_BOARD_VGA_PORT_EN
    .vga_x         (vga_x),
    .vga_y         (vga_y),
    .vga_rdata     (vga_rdata),
`endif
    .total_lines   (total_lines)
  );

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge CLOCK_50);
  endtask

  task automatic rd(input int x, input int y, output logic v);
    board_rx = 4'(x);
    board_ry = 5'(y);
    #0.1;
    v = board_rdata;
  endtask

  task automatic read_row(input int y, output logic [9:0] v);
    logic b;
    for (int x = 0; x < 10; x++) begin
      rd(x, y, b);
      v[x] = b;
    end
  endtask

  task automatic count_ones(output int ones);
    logic b;
    ones = 0;
    for (int y = 0; y < 20; y++)
      for (int x = 0; x < 10; x++) begin
        rd(x, y, b);
        if (b === 1'b1) ones++;
      end
  endtask

  task automatic wr(input int x, input int y, input logic d);
    board_we    = 1'b1;
    board_wx    = 4'(x);
    board_wy    = 5'(y);
    board_wdata = d;
    step();
    board_we    = 1'b0;
  endtask

  task automatic pulse_req();
    clear_req = 1'b1;
    step();
    clear_req = 1'b0;
  endtask

  // Counts falling edges from the request edge until clear_done is seen.
  task automatic wait_done(input int start, output int n);
    n = start;
    while (clear_done !== 1'b1 && n < 500) begin
      step();
      n++;
    end
  endtask

  initial begin
    logic       b;
    logic [9:0] row;
    int         n, extra, ones;

    resetn = 1'b0; board_rx = '0; board_ry = '0; board_we = 1'b0;
    board_wx = '0; board_wy = '0; board_wdata = 1'b0; clear_req = 1'b0;
    step(); step();
    resetn = 1'b1;
    step();

    // Reset state and range checks
    rd(3, 5, b);  check("rd_3_5", 32'(b), 32'd0);
    rd(10, 0, b); check("rd_oor_x", 32'(b), 32'd1);
    rd(0, 20, b); check("rd_oor_y", 32'(b), 32'd1);
    check("rst_busy", 32'(clear_busy), 32'd0);
    check("rst_done", 32'(clear_done), 32'd0);
    check("rst_lines", 32'(lines_cleared), 32'd0);
    check("rst_total", 32'(total_lines), 32'd0);

    // Read-during-write returns old value, new value next cycle
    board_we = 1'b1; board_wx = 4'd4; board_wy = 5'd19; board_wdata = 1'b1;
    rd(4, 19, b); check("rdw_old", 32'(b), 32'd0);
    step();
    board_we = 1'b0;
    rd(4, 19, b); check("rdw_new", 32'(b), 32'd1);

    // Out-of-range write dropped
    wr(12, 3, 1'b1);
    read_row(3, row); check("oor_write_row3", 32'(row), 32'h000);
    count_ones(ones); check("oor_write_total", 32'(ones), 32'd1);

    // Single full bottom row
    for (int x = 0; x < 10; x++) wr(x, 19, 1'b1);
    pulse_req();
    check("one_busy", 32'(clear_busy), 32'd1);
    wait_done(0, n);
    check("one_cycles", 32'(n), 32'd41);
    check("one_busy_done", 32'(clear_busy), 32'd1);
    step();
    check("one_done_pulse", 32'(clear_done), 32'd0);
    check("one_busy_end", 32'(clear_busy), 32'd0);
    check("one_lines", 32'(lines_cleared), 32'd1);
    check("one_total", 32'(total_lines), 32'd1);
    read_row(19, row); check("one_row19", 32'(row), 32'h000);

    // Empty board pass
    pulse_req();
    wait_done(0, n);
    check("empty_cycles", 32'(n), 32'd20);
    step();
    check("empty_lines", 32'(lines_cleared), 32'd0);
    check("empty_total", 32'(total_lines), 32'd1);

    // Two full rows plus a stray cell; last write coincides with clear_req
    for (int x = 0; x < 10; x++) wr(x, 19, 1'b1);
    for (int x = 0; x < 9; x++)  wr(x, 18, 1'b1);
    wr(2, 17, 1'b1);
    board_we = 1'b1; board_wx = 4'd9; board_wy = 5'd18; board_wdata = 1'b1;
    clear_req = 1'b1;
    step();
    board_we = 1'b0; clear_req = 1'b0;
    wait_done(0, n);
    check("two_cycles", 32'(n), 32'd62);
    step();
    check("two_lines", 32'(lines_cleared), 32'd2);
    check("two_total", 32'(total_lines), 32'd3);
    read_row(19, row); check("two_row19", 32'(row), 32'h004);
    read_row(18, row); check("two_row18", 32'(row), 32'h000);
    read_row(17, row); check("two_row17", 32'(row), 32'h000);

    // Write and second request while busy are both ignored
    pulse_req();
    board_we = 1'b1; board_wx = 4'd0; board_wy = 5'd0; board_wdata = 1'b1;
    clear_req = 1'b1;
    step();
    board_we = 1'b0; clear_req = 1'b0;
    wait_done(1, n);
    check("busy_cycles", 32'(n), 32'd20);
    extra = 0;
    repeat (40) begin
      step();
      if (clear_done === 1'b1) extra++;
    end
    check("busy_single_done", 32'(extra), 32'd0);
    check("busy_lines", 32'(lines_cleared), 32'd0);
    check("busy_total", 32'(total_lines), 32'd3);
    rd(0, 0, b); check("busy_write_dropped", 32'(b), 32'd0);

    // Reset in the middle of a collapse
    for (int x = 0; x < 10; x++) wr(x, 19, 1'b1);
    pulse_req();
    step(); step();
    check("mid_busy", 32'(clear_busy), 32'd1);
    resetn = 1'b0;
    #0.1;
    check("mid_rst_busy", 32'(clear_busy), 32'd0);
    check("mid_rst_total", 32'(total_lines), 32'd0);
    check("mid_rst_lines", 32'(lines_cleared), 32'd0);
    count_ones(ones); check("mid_rst_grid", 32'(ones), 32'd0);
    step();
    resetn = 1'b1;
    step();
    check("post_rst_busy", 32'(clear_busy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule : tb_tetris_board_store
